// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the fetch PC, keeps at most one
// memory request in flight and parks a response that arrives during a stall in a skid entry.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [6:0]  op_d,
  output logic [2:0]  funct3_d,
  output logic        funct7b5_d
);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  WAIT = 2'd1;
  localparam logic [1:0]  DROP = 2'd2;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        issue;
  logic        rsp_accept;

  // A new request may overlap the response of the previous one, but only when
  // that response can be consumed this cycle, so one request is ever in flight.
  assign imem_req   = !reset && !redirect && (!buf_valid || !stall_d) &&
                      (state == IDLE || (imem_rvalid && !stall_d));
  assign imem_addr  = pc_f;
  assign issue      = imem_req && imem_gnt;
  assign rsp_accept = (state == WAIT) && imem_rvalid && !redirect;

  // fetch control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_f      <= RESET_PC;
      req_pc    <= RESET_PC;
      buf_valid <= 1'b0;
    end else if (redirect) begin
      pc_f      <= {redirect_pc[31:2], 2'b00};
      buf_valid <= 1'b0;
      state     <= (state == WAIT && !imem_rvalid) ? DROP : IDLE;
    end else begin
      if (issue) begin
        req_pc <= pc_f;
        pc_f   <= pc_f + 32'd4;
        state  <= WAIT;
      end else if (imem_req || imem_rvalid) begin
        state  <= IDLE;
      end
      if (rsp_accept && stall_d) begin
        buf_valid <= 1'b1;
      end else if (buf_valid && !stall_d && !flush_d) begin
        buf_valid <= 1'b0;
      end
    end
  end

  // skid payload
  always_ff @(posedge clk) begin
    if (rsp_accept && stall_d) begin
      buf_instr <= imem_rdata;
      buf_pc    <= req_pc;
    end
  end

  // IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d   <= 1'b0;
      instr_d   <= NOP;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
    end else if (flush_d) begin
      valid_d   <= 1'b0;
      instr_d   <= NOP;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
    end else if (stall_d) begin
      valid_d   <= valid_d;
    end else if (buf_valid) begin
      valid_d   <= 1'b1;
      instr_d   <= buf_instr;
      pc_d      <= buf_pc;
      pcplus4_d <= buf_pc + 32'd4;
    end else if (rsp_accept) begin
      valid_d   <= 1'b1;
      instr_d   <= imem_rdata;
      pc_d      <= req_pc;
      pcplus4_d <= req_pc + 32'd4;
    end else begin
      valid_d   <= 1'b0;
      instr_d   <= NOP;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
    end
  end

  assign op_d       = instr_d[6:0];
  assign funct3_d   = instr_d[14:12];
  assign funct7b5_d = instr_d[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table, directed corner sequences and a randomized run
// checked against an in-order queue of granted fetch addresses.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_d, flush_d, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;
  logic [6:0]  op_d;
  logic [2:0]  funct3_d;
  logic        funct7b5_d;

  fetch_stage dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .flush_d(flush_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .op_d(op_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d)
  );

  // second instance with a wrapping reset PC and an always-ready zero-wait memory
  logic        rst1;
  logic        req1, rvalid1;
  logic [31:0] addr1, rdata1;
  logic [31:0] instr1, pc1, pcp41;
  logic        valid1, f7b1;
  logic [6:0]  op1;
  logic [2:0]  f31;
  logic        one1 = 1'b1;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .reset(rst1), .imem_req(req1), .imem_addr(addr1),
    .imem_gnt(one1), .imem_rvalid(rvalid1), .imem_rdata(rdata1),
    .stall_d(zero1), .flush_d(zero1), .redirect(zero1), .redirect_pc(zero32),
    .instr_d(instr1), .pc_d(pc1), .pcplus4_d(pcp41), .valid_d(valid1),
    .op_d(op1), .funct3_d(f31), .funct7b5_d(f7b1)
  );

  always @(posedge clk) begin
    rvalid1 <= req1;
    rdata1  <= addr1;
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] mask = 32'd0;

  // memory model state
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_cnt = 0;
  int          gnt_prob = 100;
  int          dmin = 1, dmax = 1;

  // reference: addresses granted but not yet seen in decode, oldest first
  bit          model_on = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch = 32'd0;
  int          pops = 0;

  bit          s_req, s_grant;
  logic [31:0] s_addr;

  typedef struct {
    logic        stall, flush, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ mask;
  endfunction

  function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rp,
                              input logic q, input logic [31:0] a, input logic v, input logic [31:0] p);
    vec_t t;
    t.stall = s; t.flush = f; t.redir = r; t.rpc = rp;
    t.req = q; t.addr = a; t.valid = v; t.pc = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    pend = 1'b0;
    exp_q.delete();
    exp_fetch = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: starts and ends 1 time unit after a rising edge.
  task automatic cycle();
    logic        st, fl, rd, sv;
    logic [31:0] rt, si, sp;
    bit          rsp;
    st = stall_d; fl = flush_d; rd = redirect; rt = redirect_pc;
    si = instr_d; sp = pc_d; sv = valid_d;
    rsp = pend && (pend_cnt == 0);
    imem_rvalid = rsp;
    imem_rdata  = rsp ? memw(pend_addr) : 32'hDEAD_BEEF;
    imem_gnt    = ($urandom_range(99) < gnt_prob);
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_grant = imem_req && imem_gnt;
    chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    if (pend && !rsp) chk("req_while_wait", {31'd0, imem_req}, 32'd0);
    if (rd) chk("req_in_redirect", {31'd0, imem_req}, 32'd0);
    if (model_on && s_grant) begin
      chk("fetch_addr", s_addr, exp_fetch);
      exp_q.push_back(s_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    @(posedge clk);
    if (rsp) pend = 1'b0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (s_grant) begin
      pend = 1'b1;
      pend_addr = s_addr;
      pend_cnt = $urandom_range(dmax, dmin) - 1;
    end
    #1;
    chk("pcplus4", pcplus4_d, valid_d ? pc_d + 32'd4 : 32'd0);
    chk("slices", {21'd0, op_d, funct3_d, funct7b5_d}, {21'd0, instr_d[6:0], instr_d[14:12], instr_d[30]});
    if (model_on) begin
      if (fl) begin
        chk("flush_valid", {31'd0, valid_d}, 32'd0);
        chk("flush_instr", instr_d, 32'h0000_0013);
        chk("flush_pc", pc_d, 32'd0);
      end else if (st) begin
        chk("hold_valid", {31'd0, valid_d}, {31'd0, sv});
        chk("hold_instr", instr_d, si);
        chk("hold_pc", pc_d, sp);
      end else if (valid_d) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_instr actual=pc %h required=no valid instruction", pc_d);
        end else begin
          chk("pc_order", pc_d, exp_q[0]);
          chk("instr_data", instr_d, memw(exp_q[0]));
          void'(exp_q.pop_front());
          pops++;
        end
      end
      if (rd) begin
        exp_q.delete();
        exp_fetch = {rt[31:2], 2'b00};
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rst1 = 1'b1;
    stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

    // zero-wait memory, instr = addr; expectations are IF/ID after each edge
    tbl[0]  = mk(0, 0, 0, 32'h0,   1, 32'h000, 0, 32'h000);
    tbl[1]  = mk(0, 0, 0, 32'h0,   1, 32'h004, 1, 32'h000);
    tbl[2]  = mk(0, 0, 0, 32'h0,   1, 32'h008, 1, 32'h004);
    tbl[3]  = mk(0, 0, 0, 32'h0,   1, 32'h00C, 1, 32'h008);
    tbl[4]  = mk(0, 0, 0, 32'h0,   1, 32'h010, 1, 32'h00C);
    tbl[5]  = mk(1, 0, 0, 32'h0,   0, 32'h014, 1, 32'h00C);
    tbl[6]  = mk(1, 0, 0, 32'h0,   0, 32'h014, 1, 32'h00C);
    tbl[7]  = mk(0, 0, 0, 32'h0,   1, 32'h014, 1, 32'h010);
    tbl[8]  = mk(0, 0, 0, 32'h0,   1, 32'h018, 1, 32'h014);
    tbl[9]  = mk(0, 0, 0, 32'h0,   1, 32'h01C, 1, 32'h018);
    tbl[10] = mk(0, 0, 0, 32'h0,   1, 32'h020, 1, 32'h01C);
    tbl[11] = mk(0, 0, 1, 32'h103, 0, 32'h024, 0, 32'h000);
    tbl[12] = mk(0, 0, 0, 32'h0,   1, 32'h100, 0, 32'h000);
    tbl[13] = mk(0, 0, 0, 32'h0,   1, 32'h104, 1, 32'h100);
    tbl[14] = mk(1, 1, 0, 32'h0,   0, 32'h108, 0, 32'h000);
    tbl[15] = mk(0, 0, 0, 32'h0,   1, 32'h108, 1, 32'h104);
    tbl[16] = mk(0, 0, 0, 32'h0,   1, 32'h10C, 1, 32'h108);
    tbl[17] = mk(0, 0, 0, 32'h0,   1, 32'h110, 1, 32'h10C);

    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, 32'h0000_0013);
    chk("rst_pc", pc_d, 32'd0);
    chk("rst_pcplus4", pcplus4_d, 32'd0);
    chk("rst1_addr", addr1, 32'hFFFF_FFF8);

    // table-driven zero-wait sequence
    do_reset();
    model_on = 1'b0; mask = 32'd0; gnt_prob = 100; dmin = 1; dmax = 1;
    for (int i = 0; i < 18; i++) begin
      stall_d = tbl[i].stall; flush_d = tbl[i].flush;
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      cycle();
      chk($sformatf("t%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].req});
      chk($sformatf("t%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), {31'd0, valid_d}, {31'd0, tbl[i].valid});
      chk($sformatf("t%0d_pc", i), pc_d, tbl[i].pc);
      chk($sformatf("t%0d_instr", i), instr_d, tbl[i].valid ? tbl[i].pc : 32'h0000_0013);
    end
    stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0;

    // wrapping reset PC
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] e, e4;
      @(negedge clk);
      chk($sformatf("w%0d_req", k), {31'd0, req1}, 32'd1);
      chk($sformatf("w%0d_addr", k), addr1, 32'hFFFF_FFF8 + 32'd4 * k);
      @(posedge clk);
      #1;
      if (k >= 1) begin
        e  = 32'hFFFF_FFF8 + 32'd4 * (k - 1);
        e4 = e + 32'd4;
        chk($sformatf("w%0d_pc", k), pc1, e);
        chk($sformatf("w%0d_instr", k), instr1, e);
        chk($sformatf("w%0d_pcplus4", k), pcp41, e4);
        chk($sformatf("w%0d_valid", k), {31'd0, valid1}, 32'd1);
      end
    end

    // three-cycle memory latency, redirect to 0x103 while waiting for 0x20
    do_reset();
    model_on = 1'b1; mask = 32'd0; gnt_prob = 100; dmin = 3; dmax = 3;
    begin
      bit trig = 1'b0, got = 1'b0, first_v = 1'b0;
      for (int c = 0; c < 80; c++) begin
        bit r_now;
        r_now = !trig && pend && (pend_addr == 32'h20) && (pend_cnt > 0);
        redirect = r_now;
        redirect_pc = 32'h103;
        cycle();
        redirect = 1'b0;
        if (r_now) trig = 1'b1;
        else if (trig) begin
          if (s_grant && !got) begin
            got = 1'b1;
            chk("redir_target_addr", s_addr, 32'h100);
          end
          if (valid_d && !first_v) begin
            first_v = 1'b1;
            chk("redir_first_pc", pc_d, 32'h100);
          end
        end
      end
      chk("redir_triggered", {31'd0, trig}, 32'd1);
      chk("redir_target_seen", {31'd0, got}, 32'd1);
      chk("redir_valid_seen", {31'd0, first_v}, 32'd1);
    end

    // reset while a response is outstanding
    do_reset();
    model_on = 1'b0; gnt_prob = 100; dmin = 3; dmax = 3;
    cycle();
    chk("mr_grant0", {31'd0, s_grant}, 32'd1);
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("mr_stale_ignored", {31'd0, valid_d}, 32'd0);
    chk("mr_regrant_req", {31'd0, s_req}, 32'd1);
    chk("mr_regrant_addr", s_addr, 32'd0);
    cycle();
    chk("mr_wait1_valid", {31'd0, valid_d}, 32'd0);
    cycle();
    chk("mr_wait2_valid", {31'd0, valid_d}, 32'd0);
    cycle();
    chk("mr_first_valid", {31'd0, valid_d}, 32'd1);
    chk("mr_first_pc", pc_d, 32'd0);

    // randomized traffic against the queue model
    do_reset();
    model_on = 1'b1; mask = 32'h1357_9BDF; gnt_prob = 70; dmin = 1; dmax = 3; pops = 0;
    for (int c = 0; c < 1500; c++) begin
      stall_d = ($urandom_range(99) < 25);
      redirect = ($urandom_range(99) < 4);
      flush_d = redirect;
      redirect_pc = $urandom;
      cycle();
    end
    stall_d = 1'b0; flush_d = 1'b0; redirect = 1'b0; gnt_prob = 100;
    for (int c = 0; c < 10; c++) cycle();
    chk("rand_progress", {31'd0, (pops > 100)}, 32'd1);
    chk("drain_queue_bounded", {31'd0, (exp_q.size() <= 2)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
